// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_pkg
// Purpose  : Shared Y86-64 encodings for the execute stage: instruction
//            codes, ALU functions, branch/cmov condition codes, status codes
//            and the register-none marker, plus the condition evaluator.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package execute_stage_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // ALU functions
   localparam logic [3:0] ALUADD = 4'h0;
   localparam logic [3:0] ALUSUB = 4'h1;
   localparam logic [3:0] ALUAND = 4'h2;
   localparam logic [3:0] ALUXOR = 4'h3;

   // Branch / conditional-move conditions
   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   // Status codes
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   // Condition-code register image, packed as {ZF,SF,OF}
   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   // True when a status code stops the machine (flags must not change)
   function automatic logic stat_exceptional(input logic [2:0] stat);
      return (stat == SADR) || (stat == SINS) || (stat == SHLT);
   endfunction

   // Evaluate a jump/cmov condition against the current flags
   function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
      logic lt;
      lt = cc.sf ^ cc.of;
      case (ifun)
         C_YES:   return 1'b1;
         C_LE:    return lt | cc.zf;
         C_L:     return lt;
         C_E:     return cc.zf;
         C_NE:    return ~cc.zf;
         C_GE:    return ~lt;
         C_G:     return ~lt & ~cc.zf;
         default: return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Purpose  : Bundles the E-register inputs, pipeline control, forwarding
//            outputs and M-register outputs of the execute stage.
// Modports : slave  - the execute stage (consumes E, produces M/forwarding)
//            master - the surrounding pipeline (produces E, consumes M)
// Revision : 1.0  initial release
// ============================================================================
interface execute_stage_if;

   // Pipeline control and downstream status
   logic        M_stall_i;
   logic        M_bubble_i;
   logic [2:0]  m_stat_i;
   logic [2:0]  W_stat_i;

   // E register
   logic [2:0]  E_stat_i;
   logic [63:0] E_pc_i;
   logic [3:0]  E_icode_i;
   logic [3:0]  E_ifun_i;
   logic [63:0] E_valC_i;
   logic [63:0] E_valA_i;
   logic [63:0] E_valB_i;
   logic [3:0]  E_dstE_i;
   logic [3:0]  E_dstM_i;

   // Combinational forwarding / control
   logic [63:0] e_valE_o;
   logic [3:0]  e_dstE_o;
   logic        e_cnd_o;

   // M register
   logic [2:0]  M_stat_o;
   logic [63:0] M_pc_o;
   logic [3:0]  M_icode_o;
   logic        M_cnd_o;
   logic [63:0] M_valE_o;
   logic [63:0] M_valA_o;
   logic [3:0]  M_dstE_o;
   logic [3:0]  M_dstM_o;

   // Condition codes {ZF,SF,OF}
   logic [2:0]  cc_o;

   modport slave (
      input  M_stall_i, M_bubble_i, m_stat_i, W_stat_i,
      input  E_stat_i, E_pc_i, E_icode_i, E_ifun_i, E_valC_i,
      input  E_valA_i, E_valB_i, E_dstE_i, E_dstM_i,
      output e_valE_o, e_dstE_o, e_cnd_o,
      output M_stat_o, M_pc_o, M_icode_o, M_cnd_o, M_valE_o,
      output M_valA_o, M_dstE_o, M_dstM_o, cc_o
   );

   modport master (
      output M_stall_i, M_bubble_i, m_stat_i, W_stat_i,
      output E_stat_i, E_pc_i, E_icode_i, E_ifun_i, E_valC_i,
      output E_valA_i, E_valB_i, E_dstE_i, E_dstM_i,
      input  e_valE_o, e_dstE_o, e_cnd_o,
      input  M_stat_o, M_pc_o, M_icode_o, M_cnd_o, M_valE_o,
      input  M_valA_o, M_dstE_o, M_dstM_o, cc_o
   );

endinterface
`default_nettype wire

// File: rtl/execute_stage_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : Combinational 64-bit Y86-64 ALU computing B op A with
//            zero/sign/overflow flags. Carry out is discarded.
// Ports    : alu_a, alu_b  - operands (result is B op A)
//            alu_fun       - ALUADD/ALUSUB/ALUAND/ALUXOR
//            result        - 64-bit result
//            zf, sf, of    - flags derived from result and operands
// Revision : 1.0  initial release
// ============================================================================
module alu_unit
   import execute_stage_pkg::*;
(
   input  logic [63:0] alu_a,
   input  logic [63:0] alu_b,
   input  logic [3:0]  alu_fun,
   output logic [63:0] result,
   output logic        zf,
   output logic        sf,
   output logic        of
);

   always_comb begin
      result = 64'd0;
      of     = 1'b0;
      case (alu_fun)
         ALUADD: begin
            result = alu_b + alu_a;
            // Same-sign operands producing a different-sign sum
            of = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
         end
         ALUSUB: begin
            result = alu_b - alu_a;
            // Different-sign operands where the sign of B is not preserved
            of = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
         end
         ALUAND:  result = alu_b & alu_a;
         ALUXOR:  result = alu_b ^ alu_a;
         default: result = 64'd0;
      endcase
   end

   assign zf = (result == 64'd0);
   assign sf = result[63];

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Y86-64 execute stage. Selects ALU operands, evaluates the ALU,
//            owns the condition-code register, evaluates jump/cmov
//            conditions, and registers results into the M pipeline register.
// Ports    : clk_i    - rising-edge clock
//            rst_n_i  - synchronous active-low reset
//            eif      - execute_stage_if.slave: E inputs, M_stall/M_bubble,
//                       m_stat/W_stat, forwarding outputs, M register, cc_o
// Revision : 1.0  initial release
// ============================================================================
module execute_stage
   import execute_stage_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   execute_stage_if.slave  eif
);

   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_fun;
   logic [63:0] alu_result;
   logic        alu_zf;
   logic        alu_sf;
   logic        alu_of;
   logic        set_cc;
   logic        cnd;
   logic [3:0]  dst_e;
   cc_t         cc;

   // ------------------------------------------------------------------
   // Operand selection
   // ------------------------------------------------------------------
   always_comb begin
      alu_a = 64'd0;
      case (eif.E_icode_i)
         IRRMOVQ, IOPQ:             alu_a = eif.E_valA_i;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = eif.E_valC_i;
         ICALL, IPUSHQ:             alu_a = -64'sd8;
         IRET, IPOPQ:               alu_a = 64'd8;
         default:                   alu_a = 64'd0;
      endcase
   end

   always_comb begin
      alu_b = 64'd0;
      case (eif.E_icode_i)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ:
                  alu_b = eif.E_valB_i;
         default: alu_b = 64'd0;
      endcase
   end

   assign alu_fun = (eif.E_icode_i == IOPQ) ? eif.E_ifun_i : ALUADD;

   alu_unit u_alu (
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_fun (alu_fun),
      .result  (alu_result),
      .zf      (alu_zf),
      .sf      (alu_sf),
      .of      (alu_of)
   );

   // ------------------------------------------------------------------
   // Condition codes: an exception further down the pipe freezes the flags
   // so that state after the faulting instruction is not architecturally
   // visible.
   // ------------------------------------------------------------------
   assign set_cc = (eif.E_icode_i == IOPQ)
                 && !stat_exceptional(eif.m_stat_i)
                 && !stat_exceptional(eif.W_stat_i);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cc <= CC_RESET;
      end else if (set_cc) begin
         cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
      end
   end

   // Uses pre-edge flags, so an OPQ never sees its own result here
   assign cnd = cond_eval(cc, eif.E_ifun_i);

   // A cmov whose condition fails must not write its destination
   assign dst_e = ((eif.E_icode_i == IRRMOVQ) && !cnd) ? RNONE : eif.E_dstE_i;

   assign eif.e_valE_o = alu_result;
   assign eif.e_dstE_o = dst_e;
   assign eif.e_cnd_o  = cnd;
   assign eif.cc_o     = cc;

   // ------------------------------------------------------------------
   // M pipeline register: reset > bubble > load > hold
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || eif.M_bubble_i) begin
         eif.M_stat_o  <= 3'd0;
         eif.M_pc_o    <= 64'd0;
         eif.M_icode_o <= INOP;
         eif.M_cnd_o   <= 1'b0;
         eif.M_valE_o  <= 64'd0;
         eif.M_valA_o  <= 64'd0;
         eif.M_dstE_o  <= RNONE;
         eif.M_dstM_o  <= RNONE;
      end else if (!eif.M_stall_i) begin
         eif.M_stat_o  <= eif.E_stat_i;
         eif.M_pc_o    <= eif.E_pc_i;
         eif.M_icode_o <= eif.E_icode_i;
         eif.M_cnd_o   <= cnd;
         eif.M_valE_o  <= alu_result;
         eif.M_valA_o  <= eif.E_valA_i;
         eif.M_dstE_o  <= dst_e;
         eif.M_dstM_o  <= eif.E_dstM_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage. Inputs change
//            1 time unit after each rising edge; combinational outputs are
//            checked before the next edge and registered outputs after it.
// Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;
   import execute_stage_pkg::*;

   logic clk_i;
   logic rst_n_i;
   int   errors;
   int   checks;

   execute_stage_if eif ();

   execute_stage dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .eif     (eif)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] val_a, input logic [63:0] val_b,
                        input logic [63:0] val_c, input logic [3:0] dst_e,
                        input logic [3:0] dst_m, input logic [63:0] pc);
      eif.E_stat_i  = SAOK;
      eif.E_pc_i    = pc;
      eif.E_icode_i = icode;
      eif.E_ifun_i  = ifun;
      eif.E_valA_i  = val_a;
      eif.E_valB_i  = val_b;
      eif.E_valC_i  = val_c;
      eif.E_dstE_i  = dst_e;
      eif.E_dstM_i  = dst_m;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n_i = 1'b0;
      eif.M_stall_i  = 1'b0;
      eif.M_bubble_i = 1'b0;
      eif.m_stat_i   = SAOK;
      eif.W_stat_i   = SAOK;
      set_e(INOP, 4'h0, 64'd0, 64'd0, 64'd0, RNONE, RNONE, 64'd0);

      // Reset state
      step(); step();
      check("rst_cc",     {61'd0, eif.cc_o}, 64'h4);
      check("rst_icode",  {60'd0, eif.M_icode_o}, {60'd0, INOP});
      check("rst_dstE",   {60'd0, eif.M_dstE_o}, 64'hF);
      check("rst_dstM",   {60'd0, eif.M_dstM_o}, 64'hF);
      check("rst_valE",   eif.M_valE_o, 64'd0);
      check("rst_stat",   {61'd0, eif.M_stat_o}, 64'd0);
      rst_n_i = 1'b1;

      // OPQ SUB 5-5
      set_e(IOPQ, ALUSUB, 64'd5, 64'd5, 64'd0, 4'h2, RNONE, 64'h40);
      #1;
      check("sub_e_valE", eif.e_valE_o, 64'd0);
      check("sub_e_dstE", {60'd0, eif.e_dstE_o}, 64'h2);
      step();
      check("sub_cc",     {61'd0, eif.cc_o}, 64'h4);
      check("sub_M_valE", eif.M_valE_o, 64'd0);
      check("sub_M_icode",{60'd0, eif.M_icode_o}, 64'h6);
      check("sub_M_pc",   eif.M_pc_o, 64'h40);

      // OPQ ADD overflow
      set_e(IOPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, RNONE, 64'h42);
      #1;
      check("add_e_valE", eif.e_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      check("add_cc",     {61'd0, eif.cc_o}, 64'h3);
      check("add_M_valE", eif.M_valE_o, 64'hFFFF_FFFF_FFFF_FFFE);

      // Jumps against CC={0,1,1}: SF^OF=0
      set_e(IJXX, C_L, 64'd0, 64'd0, 64'h100, RNONE, RNONE, 64'h44);
      #1;
      check("jl_cnd",  {63'd0, eif.e_cnd_o}, 64'd0);
      eif.E_ifun_i = C_GE;
      #1;
      check("jge_cnd", {63'd0, eif.e_cnd_o}, 64'd1);

      // OPQ SUB 0-1 -> CC={0,1,0}
      set_e(IOPQ, ALUSUB, 64'd1, 64'd0, 64'd0, 4'h1, RNONE, 64'h48);
      step();
      check("neg_cc", {61'd0, eif.cc_o}, 64'h2);

      // cmovl (taken) then cmove (not taken)
      set_e(IRRMOVQ, C_L, 64'h1234, 64'd0, 64'd0, 4'h3, RNONE, 64'h4A);
      #1;
      check("cmovl_e_dstE", {60'd0, eif.e_dstE_o}, 64'h3);
      check("cmovl_e_valE", eif.e_valE_o, 64'h1234);
      step();
      check("cmovl_M_cnd",  {63'd0, eif.M_cnd_o}, 64'd1);
      check("cmovl_M_dstE", {60'd0, eif.M_dstE_o}, 64'h3);
      set_e(IRRMOVQ, C_E, 64'h1234, 64'd0, 64'd0, 4'h3, RNONE, 64'h4C);
      #1;
      check("cmove_e_dstE", {60'd0, eif.e_dstE_o}, 64'hF);
      step();
      check("cmove_M_cnd",  {63'd0, eif.M_cnd_o}, 64'd0);
      check("cmove_M_dstE", {60'd0, eif.M_dstE_o}, 64'hF);

      // Exceptional downstream status freezes CC, M still loads
      eif.m_stat_i = SADR;
      set_e(IOPQ, ALUXOR, 64'd3, 64'd3, 64'd0, 4'h5, RNONE, 64'h4E);
      step();
      check("madr_cc",     {61'd0, eif.cc_o}, 64'h2);
      check("madr_M_icode",{60'd0, eif.M_icode_o}, 64'h6);
      check("madr_M_valE", eif.M_valE_o, 64'd0);
      eif.m_stat_i = SAOK;
      eif.W_stat_i = SHLT;
      set_e(IOPQ, ALUSUB, 64'd5, 64'd5, 64'd0, 4'h5, RNONE, 64'h50);
      step();
      check("whlt_cc", {61'd0, eif.cc_o}, 64'h2);
      eif.W_stat_i = SAOK;

      // PUSHQ: rsp - 8
      set_e(IPUSHQ, 4'h0, 64'hAA, 64'h100, 64'd0, 4'h4, RNONE, 64'h52);
      #1;
      check("push_e_valE", eif.e_valE_o, 64'hF8);
      step();
      check("push_M_valE", eif.M_valE_o, 64'hF8);
      check("push_M_valA", eif.M_valA_o, 64'hAA);

      // Stall holds M for two cycles while E changes
      eif.M_stall_i = 1'b1;
      set_e(IIRMOVQ, 4'h0, 64'd0, 64'd0, 64'h55, 4'h5, RNONE, 64'h54);
      step();
      check("stall1_valE",  eif.M_valE_o, 64'hF8);
      set_e(IIRMOVQ, 4'h0, 64'd0, 64'd0, 64'h66, 4'h6, RNONE, 64'h5E);
      step();
      check("stall2_valE",  eif.M_valE_o, 64'hF8);
      check("stall2_icode", {60'd0, eif.M_icode_o}, 64'hA);
      eif.M_stall_i = 1'b0;
      step();
      check("unstall_valE",  eif.M_valE_o, 64'h66);
      check("unstall_icode", {60'd0, eif.M_icode_o}, 64'h3);
      check("unstall_dstE",  {60'd0, eif.M_dstE_o}, 64'h6);

      // Bubble wins over stall
      eif.M_stall_i  = 1'b1;
      eif.M_bubble_i = 1'b1;
      step();
      check("bub_icode", {60'd0, eif.M_icode_o}, 64'h1);
      check("bub_dstE",  {60'd0, eif.M_dstE_o}, 64'hF);
      check("bub_dstM",  {60'd0, eif.M_dstM_o}, 64'hF);
      check("bub_valE",  eif.M_valE_o, 64'd0);
      eif.M_stall_i  = 1'b0;
      eif.M_bubble_i = 1'b0;

      // Mid-stream reset after CC={0,1,1}
      set_e(IOPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, RNONE, 64'h60);
      step();
      check("pre_rst_cc", {61'd0, eif.cc_o}, 64'h3);
      rst_n_i = 1'b0;
      eif.M_stall_i = 1'b1;
      set_e(IOPQ, ALUADD, 64'd1, 64'd1, 64'd0, 4'h1, 4'h2, 64'h62);
      step();
      check("mrst_cc",    {61'd0, eif.cc_o}, 64'h4);
      check("mrst_icode", {60'd0, eif.M_icode_o}, 64'h1);
      check("mrst_valE",  eif.M_valE_o, 64'd0);
      check("mrst_dstM",  {60'd0, eif.M_dstM_o}, 64'hF);
      rst_n_i = 1'b1;
      eif.M_stall_i = 1'b0;
      set_e(IIRMOVQ, 4'h0, 64'd0, 64'd0, 64'h77, 4'h6, RNONE, 64'h64);
      step();
      check("resume_valE",  eif.M_valE_o, 64'h77);
      check("resume_icode", {60'd0, eif.M_icode_o}, 64'h3);
      check("resume_stat",  {61'd0, eif.M_stat_o}, 64'h1);
      check("resume_cc",    {61'd0, eif.cc_o}, 64'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
